// File: rtl/chiselwatt_clk_pkg.sv
// Shared definitions for the Chiselwatt clock/reset sequencing logic:
// sequencer state encoding, default cycle counts and counter sizing.
package chiselwatt_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    QUALIFY   = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } seq_state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_LOCK_CYCLES = 1024;
  localparam int DEF_HOLD_CYCLES = 16;
  localparam int DEF_BTN_CYCLES  = 65536;

  // Width needed to hold the largest of the three cycle counts.
  function automatic int cnt_width(input int lock_cycles, input int hold_cycles,
                                   input int btn_cycles);
    int max_cycles;
    max_cycles = lock_cycles;
    if (hold_cycles > max_cycles) max_cycles = hold_cycles;
    if (btn_cycles > max_cycles) max_cycles = btn_cycles;
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Multi-flop synchroniser for an asynchronous input, with an optional
// low-level debounce counter that emits one pulse per sustained low period.
module sync_debounce
  import chiselwatt_clk_pkg::*;
#(
  parameter int STAGES   = DEF_SYNC_STAGES,
  parameter bit DEBOUNCE = 1'b1,
  parameter int CYCLES   = DEF_BTN_CYCLES,
  parameter int CNT_W    = 17
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic press
);

  logic [STAGES-1:0] chain;
  logic [CNT_W-1:0]  cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], raw};
    end
  end

  assign level = chain[STAGES-1];

  // Counter saturates at CYCLES-1 while held low, so a long press pulses once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (level) begin
        cnt <= '0;
      end else if (cnt != CNT_W'(CYCLES - 1)) begin
        cnt   <= cnt + CNT_W'(1);
        press <= DEBOUNCE && (cnt == CNT_W'(CYCLES - 2));
      end
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Turns raw PLL lock and the user button into a clean registered core reset:
// lock must be stable for LOCK_CYCLES, then reset is held HOLD_CYCLES more.
module pll_reset_sequencer
  import chiselwatt_clk_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int BTN_CYCLES  = DEF_BTN_CYCLES,
  parameter int CNT_W       = cnt_width(LOCK_CYCLES, HOLD_CYCLES, BTN_CYCLES)
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pll_lock,
  input  logic       btn_n,
  output logic       core_reset,
  output logic       ready,
  output logic [7:0] lock_loss_count,
  output logic [1:0] state_o
);

  logic             lock_s;
  logic             btn_s;
  logic             btn_press;
  logic             unused_lock_press;
  seq_state_t       state;
  seq_state_t       state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [7:0]       loss_n;

  sync_debounce #(
    .STAGES  (SYNC_STAGES),
    .DEBOUNCE(1'b0),
    .CYCLES  (2),
    .CNT_W   (2)
  ) u_lock_sync (
    .clock  (clock),
    .reset_n(reset_n),
    .raw    (pll_lock),
    .level  (lock_s),
    .press  (unused_lock_press)
  );

  sync_debounce #(
    .STAGES  (SYNC_STAGES),
    .DEBOUNCE(1'b1),
    .CYCLES  (BTN_CYCLES),
    .CNT_W   (CNT_W)
  ) u_btn_sync (
    .clock  (clock),
    .reset_n(reset_n),
    .raw    (btn_n),
    .level  (btn_s),
    .press  (btn_press)
  );

  // Outputs are registered from the next state so they move with the state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= WAIT_LOCK;
      cnt             <= '0;
      lock_loss_count <= '0;
      core_reset      <= 1'b1;
      ready           <= 1'b0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      lock_loss_count <= loss_n;
      core_reset      <= (state_n != RUN);
      ready           <= (state_n == RUN);
    end
  end

  // Loss of lock takes priority over the button everywhere.
  always_comb begin
    state_n = state;
    cnt_n   = '0;
    loss_n  = lock_loss_count;
    case (state)
      WAIT_LOCK: begin
        if (lock_s) state_n = QUALIFY;
      end
      QUALIFY: begin
        if (!lock_s) begin
          state_n = WAIT_LOCK;
        end else if (cnt == CNT_W'(LOCK_CYCLES - 1)) begin
          state_n = HOLD;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_n = WAIT_LOCK;
        end else if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
          state_n = RUN;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_n = WAIT_LOCK;
          if (lock_loss_count != 8'hFF) loss_n = lock_loss_count + 8'd1;
        end else if (btn_press) begin
          state_n = HOLD;
        end
      end
    endcase
  end

  assign state_o = state;

endmodule
